// File: rtl/osd_ctm_mor1kx_tracebuf.sv
// osd_ctm_mor1kx_tracebuf
//   Elastic capture stage between the mor1kx execution trace port and the
//   core trace module. Qualifying trace events are written into a small
//   circular FIFO. The FIFO is drained with a valid/ready handshake. Events
//   that arrive while the FIFO is full are counted. When space becomes
//   available again, that count is sent as one in-band overflow record.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   trace_port    raw per-cycle execution trace (valid, pc, jbtarget, jal, jr)
//   out_valid     head entry valid
//   out_ready     consumer accepts head entry
//   out_pc        head pc, or drop count (zero-extended) for overflow records
//   out_npc       head jump/branch target, 0 for overflow records
//   out_jal       head jal flag, 0 for overflow records
//   out_jalr      head jr flag, 0 for overflow records
//   out_overflow  head entry is an overflow record
//   fill_level    FIFO occupancy

package osd_ctm_mor1kx_tracebuf_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] jbtarget;
        logic        jal;
        logic        jr;
    } mor1kx_trace_exec;
endpackage

module osd_ctm_mor1kx_tracebuf
    import osd_ctm_mor1kx_tracebuf_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int CNT_WIDTH   = 16,
    parameter bit CAPTURE_ALL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  mor1kx_trace_exec         trace_port,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_npc,
    output logic                     out_jal,
    output logic                     out_jalr,
    output logic                     out_overflow,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    typedef struct packed {
        logic        overflow;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        jal;
        logic        jalr;
    } entry_t;

    entry_t                 mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

    logic   qe, full, pop, space, pending, push;
    entry_t push_entry, head;

    assign fill_level = wr_ptr_q - rd_ptr_q;
    assign full       = (fill_level == FULL_LVL);
    assign out_valid  = (wr_ptr_q != rd_ptr_q);
    assign pop        = out_valid && out_ready;
    // A slot that is freed by a pop in this cycle can be reused in the same cycle.
    assign space      = !full || pop;
    assign pending    = (drop_cnt_q != '0);
    assign qe         = trace_port.valid && (CAPTURE_ALL || trace_port.jal || trace_port.jr);

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        drop_cnt_d = drop_cnt_q;
        if (space && pending) begin
            // The loss record must come before any later event. Because of
            // this, an event that arrives in the same cycle is dropped and
            // begins a new count.
            push                = 1'b1;
            push_entry.overflow = 1'b1;
            push_entry.pc       = 32'(drop_cnt_q);
            drop_cnt_d          = qe ? CNT_WIDTH'(1) : '0;
        end else if (space && qe) begin
            push            = 1'b1;
            push_entry.pc   = trace_port.pc;
            push_entry.npc  = trace_port.jbtarget;
            push_entry.jal  = trace_port.jal;
            push_entry.jalr = trace_port.jr;
        end else if (!space && qe) begin
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // The storage array has no reset. An entry is visible only when it is
    // between the pointers.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign out_overflow = out_valid ? head.overflow : 1'b0;
    assign out_pc       = out_valid ? head.pc       : 32'h0;
    assign out_npc      = out_valid ? head.npc      : 32'h0;
    assign out_jal      = out_valid ? head.jal      : 1'b0;
    assign out_jalr     = out_valid ? head.jalr     : 1'b0;

endmodule

// File: tb/tb_osd_ctm_mor1kx_tracebuf.sv
module tb_osd_ctm_mor1kx_tracebuf;
    import osd_ctm_mor1kx_tracebuf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    mor1kx_trace_exec tr, tr4;
    logic ready, ready4;

    logic        out_valid, out_jal, out_jalr, out_overflow;
    logic [31:0] out_pc, out_npc;
    logic [3:0]  fill_level;
    logic        out4_valid, out4_jal, out4_jalr, out4_overflow;
    logic [31:0] out4_pc, out4_npc;
    logic [3:0]  fill4_level;

    int n_assert = 0;
    int n_fail   = 0;
    logic [66:0] sb  [$];
    logic [66:0] sb4 [$];

    always #5 clk = ~clk;

    osd_ctm_mor1kx_tracebuf #(.DEPTH(8), .CNT_WIDTH(16), .CAPTURE_ALL(1'b0)) dut (
        .clk(clk), .rst(rst), .trace_port(tr),
        .out_valid(out_valid), .out_ready(ready),
        .out_pc(out_pc), .out_npc(out_npc), .out_jal(out_jal), .out_jalr(out_jalr),
        .out_overflow(out_overflow), .fill_level(fill_level)
    );

    osd_ctm_mor1kx_tracebuf #(.DEPTH(8), .CNT_WIDTH(4), .CAPTURE_ALL(1'b1)) dut4 (
        .clk(clk), .rst(rst), .trace_port(tr4),
        .out_valid(out4_valid), .out_ready(ready4),
        .out_pc(out4_pc), .out_npc(out4_npc), .out_jal(out4_jal), .out_jalr(out4_jalr),
        .out_overflow(out4_overflow), .fill_level(fill4_level)
    );

    function automatic logic [66:0] mk(logic ovf, logic [31:0] pc, logic [31:0] npc,
                                       logic jal, logic jr);
        return {ovf, pc, npc, jal, jr};
    endfunction

    task automatic chk(string tag, logic [66:0] got, logic [66:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(logic [31:0] pc, logic [31:0] npc, logic jal, logic jr);
        tr.valid = 1'b1; tr.pc = pc; tr.jbtarget = npc; tr.jal = jal; tr.jr = jr;
    endtask

    task automatic idle();
        tr  = '0;
        tr4 = '0;
    endtask

    // Check any handshake at the negedge, then move past the next rising edge.
    task automatic tick();
        logic [66:0] got;
        @(negedge clk);
        if (out_valid && ready) begin
            got = {out_overflow, out_pc, out_npc, out_jal, out_jalr};
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected got=%0h expected=no output", got);
            end
            if (sb.size() > 0) chk("sb_entry", got, sb.pop_front());
        end
        if (out4_valid && ready4) begin
            got = {out4_overflow, out4_pc, out4_npc, out4_jal, out4_jalr};
            n_assert++;
            assert (sb4.size() > 0) else begin
                n_fail++;
                $error("FAIL sb4_unexpected got=%0h expected=no output", got);
            end
            if (sb4.size() > 0) chk("sb4_entry", got, sb4.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; ready4 = 1'b0;
        idle();
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_fill", fill_level, 4'd0);
        chk("rst_head", {out_overflow, out_pc, out_npc, out_jal, out_jalr}, 67'd0);

        // Filter test: a non-jump instruction is skipped, and jal and jr are captured.
        ready = 1'b1;
        drive(32'h100, 32'h0, 1'b0, 1'b0);
        tick();
        chk("filter_skip", out_valid, 1'b0);
        drive(32'h104, 32'h200, 1'b1, 1'b0);
        sb.push_back(mk(1'b0, 32'h104, 32'h200, 1'b1, 1'b0));
        tick();
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_pc", out_pc, 32'h104);
        drive(32'h200, 32'h108, 1'b0, 1'b1);
        sb.push_back(mk(1'b0, 32'h200, 32'h108, 1'b0, 1'b1));
        tick();
        chk("lat2_pc", out_pc, 32'h200);
        idle();
        tick();
        chk("t1_empty", out_valid, 1'b0);
        chk("t1_fill", fill_level, 4'd0);

        // Send 11 jal events while stalled: 8 are buffered and 3 are dropped.
        ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive(32'h1000 + 32'(4 * i), 32'h2000 + 32'(i), 1'b1, 1'b0);
            if (i < 8) sb.push_back(mk(1'b0, 32'h1000 + 32'(4 * i), 32'h2000 + 32'(i), 1'b1, 1'b0));
            tick();
        end
        idle();
        tick();
        chk("t2_fill", fill_level, 4'd8);
        chk("t2_hold_pc", out_pc, 32'h1000);
        ready = 1'b1;
        sb.push_back(mk(1'b1, 32'd3, 32'd0, 1'b0, 1'b0));
        for (int i = 0; i < 11; i++) tick();
        chk("t2_drained", out_valid, 1'b0);
        chk("t2_sb", 67'(sb.size()), 67'd0);

        // A QE arrives in the same cycle that space frees while drops are
        // pending. The QE is dropped, and the next overflow record reports 1.
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(32'h3000 + 32'(4 * i), 32'h0, 1'b1, 1'b0);
            if (i < 8) sb.push_back(mk(1'b0, 32'h3000 + 32'(4 * i), 32'h0, 1'b1, 1'b0));
            tick();
        end
        ready = 1'b1;
        drive(32'h4000, 32'h4004, 1'b1, 1'b0);
        sb.push_back(mk(1'b1, 32'd2, 32'd0, 1'b0, 1'b0));
        tick();
        idle();
        sb.push_back(mk(1'b1, 32'd1, 32'd0, 1'b0, 1'b0));
        for (int i = 0; i < 12; i++) tick();
        chk("t3_sb", 67'(sb.size()), 67'd0);
        chk("t3_fill", fill_level, 4'd0);

        // Full FIFO with one push and one pop per cycle: no events are dropped.
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(32'h8000 + 32'(4 * i), 32'h9000, 1'b0, 1'b1);
            sb.push_back(mk(1'b0, 32'h8000 + 32'(4 * i), 32'h9000, 1'b0, 1'b1));
            tick();
        end
        ready = 1'b1;
        for (int i = 8; i < 28; i++) begin
            drive(32'h8000 + 32'(4 * i), 32'h9000, 1'b0, 1'b1);
            sb.push_back(mk(1'b0, 32'h8000 + 32'(4 * i), 32'h9000, 1'b0, 1'b1));
            tick();
            chk("t4_fill", fill_level, 4'd8);
        end
        idle();
        for (int i = 0; i < 10; i++) tick();
        chk("t4_sb", 67'(sb.size()), 67'd0);

        // 4-bit counter with capture of all instructions: 40 drops saturate at 15.
        ready4 = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tr4.valid = 1'b1; tr4.pc = 32'h5000 + 32'(4 * i);
            tr4.jbtarget = 32'h0; tr4.jal = 1'b0; tr4.jr = 1'b0;
            if (i < 8) sb4.push_back(mk(1'b0, 32'h5000 + 32'(4 * i), 32'h0, 1'b0, 1'b0));
            tick();
        end
        idle();
        tick();
        chk("t5_fill", fill4_level, 4'd8);
        ready4 = 1'b1;
        sb4.push_back(mk(1'b1, 32'd15, 32'd0, 1'b0, 1'b0));
        for (int i = 0; i < 11; i++) tick();
        chk("t5_sb", 67'(sb4.size()), 67'd0);
        chk("t5_empty", out4_valid, 1'b0);

        // Reset in the middle of operation, with a QE present during the reset cycle.
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(32'hA000 + 32'(4 * i), 32'h0, 1'b1, 1'b0);
            tick();
        end
        sb.delete();
        rst = 1'b1;
        drive(32'hB000, 32'hB100, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        idle();
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_fill", fill_level, 4'd0);
        ready = 1'b1;
        drive(32'h6000, 32'h7000, 1'b1, 1'b0);
        sb.push_back(mk(1'b0, 32'h6000, 32'h7000, 1'b1, 1'b0));
        tick();
        chk("t6_first_ovf", out_overflow, 1'b0);
        chk("t6_first_pc", out_pc, 32'h6000);
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("t6_sb", 67'(sb.size()), 67'd0);
        chk("t6_end_fill", fill_level, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
